// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, carry selection, flag word, FSM state.
// Also holds the carry-source mux used on both completion paths.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOT = 4'd0,
    OP_INC = 4'd1,
    OP_DEC = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    CS_ALU  = 2'b00,
    CS_SET  = 2'b01,
    CS_CLR  = 2'b10,
    CS_HOLD = 2'b11
  } carry_sel_e;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic sel_carry(input carry_sel_e cs, input logic alu_c, input logic cur_c);
    logic c;
    case (cs)
      CS_SET:  c = 1'b1;
      CS_CLR:  c = 1'b0;
      CS_HOLD: c = cur_c;
      default: c = alu_c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle; start performs the first step.
// Latency: done is high in the WIDTH-th cycle after start; abort clears it; no backpressure.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [SHW:0]       cnt_q;
  logic               run_q;

  // Upper half accumulates; lower half holds the not-yet-consumed multiplier bits.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[WIDTH-1:1]};
  endfunction

  assign done_o    = run_q && (cnt_q == (SHW+1)'(WIDTH));
  assign product_o = prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (abort_i || done_o) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      mcand_q <= a_i;
      prod_q  <= step({{WIDTH{1'b0}}, b_i}, a_i);
      cnt_q   <= (SHW+1)'(1);
      run_q   <= 1'b1;
    end else if (run_q) begin
      prod_q <= step(prod_q, mcand_q);
      cnt_q  <= cnt_q + (SHW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// ALU with single-cycle ops (latency 1) and an iterative MUL (latency WIDTH+1).
// in_ready only in IDLE, so one op is in flight at a time; flush aborts it silently.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       carry_sel,
  input  logic             flag_en,
  input  logic             flag_pop_en,
  input  logic [2:0]       flags_pop,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flags,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   result_q, result_hi_q;
  flags_t             flags_q;
  logic               out_valid_q;
  carry_sel_e         cs_q;
  logic               flag_en_q;

  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic [WIDTH:0]     wide;
  logic [SHW-1:0]     shamt;
  logic               accept, is_mul, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  function automatic flags_t mk_flags(input logic c, input logic [WIDTH-1:0] r);
    return '{c: c, n: r[WIDTH-1], z: (r == '0)};
  endfunction

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

  assign accept = in_valid && in_ready && !flush;
  assign is_mul = (alu_op == OP_MUL);
  assign shamt  = op_b[SHW-1:0];

  // The extra bit of 'wide' captures the carry/borrow or the last bit shifted out.
  always_comb begin
    res_d   = op_b;
    carry_d = 1'b0;
    wide    = '0;
    case (alu_op)
      OP_NOT: res_d = ~op_a;
      OP_INC: begin
        wide    = {1'b0, op_a} + (WIDTH+1)'(1);
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_DEC: begin
        res_d   = op_a - WIDTH'(1);
        carry_d = (op_a == '0);
      end
      OP_ADD: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_SUB: begin
        res_d   = op_a - op_b;
        carry_d = (op_a < op_b);
      end
      OP_AND: res_d = op_a & op_b;
      OP_OR:  res_d = op_a | op_b;
      OP_SHL: begin
        wide    = {1'b0, op_a} << shamt;
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_SHR: begin
        wide    = {op_a, 1'b0} >> shamt;
        res_d   = wide[WIDTH:1];
        carry_d = wide[0];
      end
      default: ;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && is_mul),
    .abort_i   (flush),
    .a_i       (op_a),
    .b_i       (op_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      cs_q        <= CS_ALU;
      flag_en_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (is_mul) begin
            state_q   <= ST_MUL;
            cs_q      <= carry_sel_e'(carry_sel);
            flag_en_q <= flag_en;
          end else begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            result_hi_q <= '0;
            if (flag_en)
              flags_q <= mk_flags(sel_carry(carry_sel_e'(carry_sel), carry_d, flags_q.c), res_d);
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (mul_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            if (flag_en_q)
              flags_q <= mk_flags(sel_carry(cs_q, |mul_prod[2*WIDTH-1:WIDTH], flags_q.c),
                                  mul_prod[WIDTH-1:0]);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A pop must override any ALU flag update on the same edge.
      if (flag_pop_en)
        flags_q <= flags_t'(flags_pop);
    end
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the datapath width (min 8, power of 2).
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  op request; in_ready  out  1  block can accept.
REQ-006 alu_op  in  4  operation code (alu_pkg::alu_op_e).
REQ-007 op_a, op_b  in  WIDTH  operands, already forwarded by the caller.
REQ-008 carry_sel  in  2  00 ALU carry, 01 set, 10 clear, 11 hold.
REQ-009 flag_en  in  1  latch ALU flags on completion.
REQ-010 flag_pop_en  in  1  load flags from flags_pop; flags_pop  in  3  {C,N,Z}.
REQ-011 flush  in  1  synchronous abort of an in-flight op.
REQ-012 out_valid  out  1  one-cycle completion pulse; result, result_hi  out  WIDTH  low/high result words.
REQ-013 flags  out  3  registered {C,N,Z}; busy  out  1  multi-cycle op in progress.

Function
REQ-014 Ops SHALL be: NOT ~a; INC a+1; DEC a-1; ADD a+b; SUB a-b; AND; OR; SHL a<<b[SHW-1:0]; SHR logical a>>b[SHW-1:0]; MUL unsigned a*b; any other code passes op_b.
REQ-015 FSM states SHALL be IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-016 Accept occurs at a rising edge with in_valid && in_ready; operands/op captured there.
REQ-017 Non-MUL ops SHALL register result at the accept edge; FSM -> DONE; out_valid = 1 the following cycle (latency 1).
REQ-018 MUL SHALL use iterative shift-add, one partial product per cycle, WIDTH cycles in MUL, then DONE; out_valid asserted WIDTH+1 cycles after accept.
REQ-019 DONE SHALL last exactly one cycle and return to IDLE; in_ready is 0 in DONE (no back-to-back accept).
REQ-020 result_hi SHALL hold the upper WIDTH product bits for MUL, 0 for all other ops.
REQ-021 ALU carry: ADD/INC carry-out; SUB/DEC borrow (a<b; DEC a==0); SHL/SHR last bit shifted out, 0 if amount 0; MUL |result_hi; NOT/AND/OR/pass 0.
REQ-022 N = result[WIDTH-1]; Z = (result == 0), low word only.
REQ-023 carry_sel 11 SHALL keep the current flags.C; N/Z still update.
REQ-024 ALU flags SHALL load into flags at the edge entering DONE only if flag_en was 1 at accept.
REQ-025 flag_pop_en SHALL load flags_pop at any edge; it wins over a coincident ALU flag update.
REQ-026 flush SHALL return FSM to IDLE next edge from MUL or DONE; no out_valid, flags and result unchanged.
REQ-027 flush concurrent with in_valid in IDLE SHALL block the accept.
REQ-028 busy = 1 in MUL only.

Reset
REQ-029 On rst_n low: FSM IDLE, result 0, result_hi 0, flags 000, out_valid 0, MUL counter 0; in_ready 1 once rst_n high.
REQ-030 Reset during MUL SHALL abort with no out_valid after release.

Structure
REQ-031 Package alu_pkg SHALL hold alu_op_e, carry_sel_e, flags_t {c,n,z} struct, and state enum.
REQ-032 Iterative multiplier SHALL be one sub-module alu_mul_iter (start, WIDTH-cycle count, done, 2*WIDTH product).

Verification
REQ-033 ADD 0xFFFF+0x0001, flag_en=1, carry_sel=00 -> out_valid next cycle, result 0x0000, flags C=1,N=0,Z=1.
REQ-034 SUB 0x0003-0x0005 -> result 0xFFFE, flags C=1,N=1,Z=0; carry_sel=10 repeat -> C=0.
REQ-035 MUL 0x0100*0x0100 -> busy 16 cycles, in_ready 0, out_valid at cycle 17, result 0x0000, result_hi 0x0001, C=1,Z=1.
REQ-036 SHL 0x8001 by 1 -> result 0x0002, C=1; SHR 0x8001 by 0 -> result 0x8001, C=0.
REQ-037 flag_pop_en with flags_pop=3'b010 on same edge as ALU flag load -> flags 3'b010.
REQ-038 rst_n low mid-MUL (cycle 5), and separately flush mid-MUL -> no out_valid, FSM IDLE, in_ready 1 next cycle.
